// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between instruction fetch and data access.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_dmtype,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_dmtype,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall,
    output logic        timeout_err
);

    localparam logic [2:0] c_dmtype_word = 3'b010;
    localparam logic [7:0] c_cnt_last    = 8'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_IF_WAIT = 2'd1,
        S_D_WAIT  = 2'd2
    } state_t;

    state_t      r_state,      w_state_nxt;
    logic [7:0]  r_cnt,        w_cnt_nxt;
    logic        r_mem_req,    w_mem_req_nxt;
    logic        r_mem_we,     w_mem_we_nxt;
    logic [31:0] r_mem_addr,   w_mem_addr_nxt;
    logic [31:0] r_mem_wdata,  w_mem_wdata_nxt;
    logic [2:0]  r_mem_dmtype, w_mem_dmtype_nxt;
    logic [31:0] r_if_rdata,   w_if_rdata_nxt;
    logic [31:0] r_d_rdata,    w_d_rdata_nxt;
    logic        r_if_ack,     w_if_ack_nxt;
    logic        r_d_ack,      w_d_ack_nxt;
    logic        r_timeout,    w_timeout_nxt;

    logic        w_finish;
    logic [31:0] w_rdata_ret;

    // A transaction ends on ready, or on the last permitted wait cycle (abort).
    assign w_finish    = mem_ready || (r_cnt == c_cnt_last);
    assign w_rdata_ret = mem_ready ? mem_rdata : 32'h0;

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_mem_req_nxt    = 1'b0;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_mem_dmtype_nxt = r_mem_dmtype;
        w_if_rdata_nxt   = r_if_rdata;
        w_d_rdata_nxt    = r_d_rdata;
        w_if_ack_nxt     = 1'b0;
        w_d_ack_nxt      = 1'b0;
        w_timeout_nxt    = r_timeout;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 8'd0;
                // A requester in its own ack cycle is still holding req; skip it.
                if (d_req && !r_d_ack) begin
                    w_mem_req_nxt    = 1'b1;
                    w_mem_we_nxt     = d_we;
                    w_mem_addr_nxt   = d_addr;
                    w_mem_wdata_nxt  = d_wdata;
                    w_mem_dmtype_nxt = d_dmtype;
                    w_state_nxt      = S_D_WAIT;
                end else if (if_req && !r_if_ack) begin
                    w_mem_req_nxt    = 1'b1;
                    w_mem_we_nxt     = 1'b0;
                    w_mem_addr_nxt   = if_addr;
                    w_mem_dmtype_nxt = c_dmtype_word;
                    w_state_nxt      = S_IF_WAIT;
                end
            end
            S_IF_WAIT, S_D_WAIT: begin
                w_mem_req_nxt = 1'b1;
                w_cnt_nxt     = r_cnt + 8'd1;
                if (w_finish) begin
                    w_mem_req_nxt = 1'b0;
                    w_cnt_nxt     = 8'd0;
                    w_state_nxt   = S_IDLE;
                    if (!mem_ready) begin
                        w_timeout_nxt = 1'b1;
                    end
                    if (r_state == S_IF_WAIT) begin
                        w_if_ack_nxt   = 1'b1;
                        w_if_rdata_nxt = w_rdata_ret;
                    end else begin
                        w_d_ack_nxt = 1'b1;
                        if (!r_mem_we) begin
                            w_d_rdata_nxt = w_rdata_ret;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_mem_wdata  <= 32'h0;
            r_mem_dmtype <= 3'b000;
            r_if_rdata   <= 32'h0;
            r_d_rdata    <= 32'h0;
            r_if_ack     <= 1'b0;
            r_d_ack      <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_dmtype <= w_mem_dmtype_nxt;
            r_if_rdata   <= w_if_rdata_nxt;
            r_d_rdata    <= w_d_rdata_nxt;
            r_if_ack     <= w_if_ack_nxt;
            r_d_ack      <= w_d_ack_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_dmtype  = r_mem_dmtype;
    assign if_rdata    = r_if_rdata;
    assign d_rdata     = r_d_rdata;
    assign if_ack      = r_if_ack;
    assign d_ack       = r_d_ack;
    assign timeout_err = r_timeout;
    assign stall       = (if_req & ~r_if_ack) | (d_req & ~r_d_ack);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench for mem_port_arbiter (vectors, corners, random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int WAIT_MAX = 4;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_dmtype;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_dmtype;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_dmtype(d_dmtype), .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_dmtype(mem_dmtype),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall(stall), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  dm;
        int          waits;
        logic [31:0] rdata;
        int          exp_ack;
        logic [31:0] exp_rd;
        logic        exp_we;
        logic [2:0]  exp_dm;
        logic        exp_to;
    } vec_t;

    vec_t vecs[7];

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Drives one isolated transaction; memory answers after v.waits wait cycles.
    task automatic run_txn(input vec_t v);
        logic        ack_v;
        logic [31:0] rd_v;
        for (int k = 0; k <= v.exp_ack + 1; k++) begin
            step();
            if (k == 0) begin
                if (v.is_d) begin
                    d_req = 1'b1; d_we = v.we; d_addr = v.addr;
                    d_wdata = v.wdata; d_dmtype = v.dm;
                end else begin
                    if_req = 1'b1; if_addr = v.addr;
                end
            end else if (k == v.exp_ack + 1) begin
                d_req = 1'b0; if_req = 1'b0;
            end
            mem_ready = (k == 0) || (k == 1 + v.waits) || (k >= v.exp_ack);
            mem_rdata = (k == 1 + v.waits) ? v.rdata : 32'hBAD0_0000 + 32'(k);
            #2;
            ack_v = v.is_d ? d_ack : if_ack;
            rd_v  = v.is_d ? d_rdata : if_rdata;
            if (k == 0) begin
                chk1("idle_mem_req", mem_req, 1'b0);
                chk1("req_stall", stall, 1'b1);
            end else if (k < v.exp_ack) begin
                chk1("wait_mem_req", mem_req, 1'b1);
                chk32("wait_mem_addr", mem_addr, v.addr);
                chk1("wait_mem_we", mem_we, v.exp_we);
                chk32("wait_mem_dmtype", 32'(mem_dmtype), 32'(v.exp_dm));
                if (v.is_d) chk32("wait_mem_wdata", mem_wdata, v.wdata);
                chk1("wait_no_ack", ack_v, 1'b0);
                chk1("wait_stall", stall, 1'b1);
            end else if (k == v.exp_ack) begin
                chk1("ack", ack_v, 1'b1);
                chk32("ack_rdata", rd_v, v.exp_rd);
                chk1("ack_timeout_err", timeout_err, v.exp_to);
                chk1("ack_mem_req", mem_req, 1'b0);
                chk1("ack_stall", stall, 1'b0);
            end else begin
                chk1("ack_single_pulse", ack_v, 1'b0);
                chk32("rdata_held", rd_v, v.exp_rd);
            end
        end
    endtask

    // Transaction-level reference state for the random phase
    bit          m_busy, m_own_d, m_to;
    int          m_g, m_w, m_ack, mcnt;
    logic [31:0] m_cap;
    logic [31:0] e_addr, e_wdata, e_if_rd, e_d_rd;
    logic        e_we, e_to, e_if_ack, e_d_ack, e_mreq;
    logic [2:0]  e_dm;
    bit          d_act, if_act;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vec_t fv;
        reset = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_dmtype = 3'b000;
        mem_rdata = 32'h0; mem_ready = 1'b0;
        #1;
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_if_ack", if_ack, 1'b0);
        chk1("rst_d_ack", d_ack, 1'b0);
        chk1("rst_timeout_err", timeout_err, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk32("rst_mem_dmtype", 32'(mem_dmtype), 32'h0);
        chk32("rst_if_rdata", if_rdata, 32'h0);
        chk32("rst_d_rdata", d_rdata, 32'h0);
        do_reset();

        //            is_d we    addr          wdata         dm      waits rdata         ack rd            we    dm      to
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,        3'b000, 0,  32'h0050_0093, 2, 32'h0050_0093, 1'b0, 3'b010, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,        3'b010, 1,  32'h1234_5678, 3, 32'h1234_5678, 1'b0, 3'b010, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 3'b000, 3,  32'hCAFE_F00D, 5, 32'h1234_5678, 1'b1, 3'b000, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,        3'b100, 2,  32'h0000_00AB, 4, 32'h0000_00AB, 1'b0, 3'b100, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,        3'b000, 3,  32'h00A0_0113, 5, 32'h00A0_0113, 1'b0, 3'b010, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,        3'b010, 99, 32'h5555_5555, 5, 32'h0,         1'b0, 3'b010, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0048, 32'h0,        3'b000, 99, 32'h6666_6666, 5, 32'h0,         1'b0, 3'b010, 1'b1};
        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        // Contention: data first, fetch granted in the d_ack cycle
        do_reset();
        for (int k = 0; k <= 5; k++) begin
            step();
            if (k == 0) begin
                if_req = 1'b1; if_addr = 32'h40;
                d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_dmtype = 3'b010;
            end
            if (k == 3) d_req = 1'b0;
            if (k == 5) if_req = 1'b0;
            mem_ready = mem_req;
            mem_rdata = 32'hA000_0000 + 32'(k);
            #2;
            case (k)
                1: begin chk1("ct_mem_req1", mem_req, 1'b1); chk32("ct_mem_addr1", mem_addr, 32'h100); end
                2: begin
                    chk1("ct_d_ack", d_ack, 1'b1); chk1("ct_if_ack2", if_ack, 1'b0);
                    chk32("ct_d_rdata", d_rdata, 32'hA000_0001); chk1("ct_stall2", stall, 1'b1);
                end
                3: begin
                    chk1("ct_mem_req3", mem_req, 1'b1); chk32("ct_mem_addr3", mem_addr, 32'h40);
                    chk1("ct_mem_we3", mem_we, 1'b0); chk32("ct_mem_dm3", 32'(mem_dmtype), 32'h2);
                end
                4: begin chk1("ct_if_ack", if_ack, 1'b1); chk32("ct_if_rdata", if_rdata, 32'hA000_0003); end
                default: ;
            endcase
        end

        // Back-to-back data: no grant in the ack cycle, re-grant with new address
        for (int k = 0; k <= 6; k++) begin
            step();
            if (k == 0) begin d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_dmtype = 3'b010; end
            if (k == 2) d_addr = 32'h504;
            if (k == 6) d_req = 1'b0;
            mem_ready = mem_req;
            mem_rdata = 32'hB000_0000 + 32'(k);
            #2;
            case (k)
                1: chk32("bb_mem_addr1", mem_addr, 32'h500);
                2: begin chk1("bb_d_ack2", d_ack, 1'b1); chk1("bb_stall2", stall, 1'b0); end
                3: chk1("bb_no_grant_in_ack", mem_req, 1'b0);
                4: begin chk1("bb_regrant", mem_req, 1'b1); chk32("bb_mem_addr4", mem_addr, 32'h504); end
                5: begin chk1("bb_d_ack5", d_ack, 1'b1); chk32("bb_d_rdata", d_rdata, 32'hB000_0004); end
                6: chk1("bb_ack_pulse", d_ack, 1'b0);
                default: ;
            endcase
        end

        // Reset in the second cycle of a D_WAIT
        for (int k = 0; k <= 2; k++) begin
            step();
            if (k == 0) begin d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600; end
            mem_ready = 1'b0;
            #2;
        end
        chk1("rm_mem_req_before", mem_req, 1'b1);
        reset = 1'b1;
        #1;
        chk1("rm_mem_req_now", mem_req, 1'b0);
        chk1("rm_d_ack_now", d_ack, 1'b0);
        step();
        reset = 1'b0; d_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk1("rm_no_ack", d_ack, 1'b0);
            chk1("rm_no_mem_req", mem_req, 1'b0);
        end
        chk1("rm_timeout_cleared", timeout_err, 1'b0);
        fv = '{1'b0, 1'b0, 32'h0000_004C, 32'h0, 3'b000, 1, 32'h0000_0013, 3, 32'h0000_0013, 1'b0, 3'b010, 1'b0};
        run_txn(fv);

        // Randomized traffic against a transaction-level model
        do_reset();
        m_busy = 0; m_own_d = 0; m_to = 0; m_g = 0; m_w = 0; m_ack = 0; mcnt = 0;
        m_cap = 32'h0; e_addr = 32'h0; e_wdata = 32'h0; e_if_rd = 32'h0; e_d_rd = 32'h0;
        e_we = 1'b0; e_dm = 3'b000; e_to = 1'b0;
        d_act = 0; if_act = 0;
        for (int c = 0; c < 1500; c++) begin
            step();
            e_if_ack = m_busy && (c == m_ack) && !m_own_d;
            e_d_ack  = m_busy && (c == m_ack) && m_own_d;
            if (d_act ? e_d_ack : ($urandom_range(0, 2) == 0)) begin
                d_act = !d_act || ($urandom_range(0, 1) == 1);
                d_addr = $urandom; d_wdata = $urandom;
                d_we = 1'($urandom_range(0, 1)); d_dmtype = 3'($urandom_range(0, 7));
            end
            if (if_act ? e_if_ack : ($urandom_range(0, 2) == 0)) begin
                if_act = !if_act || ($urandom_range(0, 1) == 1);
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            d_req = d_act; if_req = if_act;
            if (mem_req) begin
                mem_ready = (mcnt == m_w);
                mcnt++;
            end else begin
                mcnt = 0;
                mem_ready = 1'($urandom_range(0, 1));
            end
            mem_rdata = $urandom;
            #2;
            if (e_if_ack) e_if_rd = m_to ? 32'h0 : m_cap;
            if (e_d_ack && !e_we) e_d_rd = m_to ? 32'h0 : m_cap;
            if ((e_if_ack || e_d_ack) && m_to) e_to = 1'b1;
            e_mreq = m_busy && (c > m_g) && (c < m_ack);
            chk1("rnd_mem_req", mem_req, e_mreq);
            chk32("rnd_mem_addr", mem_addr, e_addr);
            chk1("rnd_mem_we", mem_we, e_we);
            chk32("rnd_mem_dmtype", 32'(mem_dmtype), 32'(e_dm));
            chk32("rnd_mem_wdata", mem_wdata, e_wdata);
            chk1("rnd_if_ack", if_ack, e_if_ack);
            chk1("rnd_d_ack", d_ack, e_d_ack);
            chk32("rnd_if_rdata", if_rdata, e_if_rd);
            chk32("rnd_d_rdata", d_rdata, e_d_rd);
            chk1("rnd_timeout_err", timeout_err, e_to);
            chk1("rnd_stall", stall, (if_req && !e_if_ack) || (d_req && !e_d_ack));
            if (m_busy && (c == m_g + 1 + m_w) && (m_w < WAIT_MAX)) m_cap = mem_rdata;
            if (m_busy && (c >= m_ack)) m_busy = 0;
            if (!m_busy && ((d_req && !e_d_ack) || (if_req && !e_if_ack))) begin
                m_own_d = d_req && !e_d_ack;
                if (m_own_d) begin
                    e_addr = d_addr; e_wdata = d_wdata; e_we = d_we; e_dm = d_dmtype;
                end else begin
                    e_addr = if_addr; e_we = 1'b0; e_dm = 3'b010;
                end
                m_busy = 1;
                m_g    = c;
                m_w    = $urandom_range(0, 6);
                m_to   = (m_w >= WAIT_MAX);
                m_ack  = c + 2 + (m_to ? WAIT_MAX - 1 : m_w);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
